ex_mem_stage: RTL

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

---
 rtl/ex_mem_stage.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/ex_mem_stage.sv
// EX stage ALU with operand forwarding feeding the EX/MEM pipeline register.
// Define EX_MEM_STAGE_FWD_EN to compile in EX/MEM and MEM/WB operand forwarding.
module ex_mem_stage #(
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic [3:0]        alu_op_i,
   input  logic [DATA_W-1:0] op1_i,
   input  logic [DATA_W-1:0] op2_i,
   input  logic [1:0]        constant_i,
   input  logic [2:0]        rd_i,
   input  logic [2:0]        rs1_i,
   input  logic [2:0]        rs2_i,
   input  logic              memRead_i,
   input  logic              memWrite_i,
   input  logic              regWrite_i,
   input  logic [2:0]        wb_rd_i,
   input  logic              wb_regWrite_i,
   input  logic [DATA_W-1:0] wb_data_i,
   output logic [DATA_W-1:0] alu_result_o,
   output logic [DATA_W-1:0] store_data_o,
   output logic [2:0]        rd_o,
   output logic              memRead_o,
   output logic              memWrite_o,
   output logic              regWrite_o,
   output logic              zero_o,
   output logic              carry_o
);

   logic [DATA_W-1:0] alu_result_q, alu_result_d;
   logic [DATA_W-1:0] store_data_q, store_data_d;
   logic [2:0]        rd_q, rd_d;
   logic              mem_read_q, mem_read_d;
   logic              mem_write_q, mem_write_d;
   logic              reg_write_q, reg_write_d;
   logic              zero_q, zero_d;
   logic              carry_q, carry_d;

   logic [DATA_W-1:0] opa, opb;
   logic [DATA_W-1:0] res;
   logic [DATA_W:0]   wide;
   logic              cy;

`ifdef EX_MEM_STAGE_FWD_EN
   // A load result is not available yet in EX/MEM, so it never forwards.
   logic ex_fwd_ok;
   assign ex_fwd_ok = reg_write_q && !mem_read_q;

   always_comb begin
      opa = op1_i;
      if (ex_fwd_ok && (rd_q == rs1_i)) begin
         opa = alu_result_q;
      end else if (wb_regWrite_i && (wb_rd_i == rs1_i)) begin
         opa = wb_data_i;
      end
      opb = op2_i;
      if (ex_fwd_ok && (rd_q == rs2_i)) begin
         opb = alu_result_q;
      end else if (wb_regWrite_i && (wb_rd_i == rs2_i)) begin
         opb = wb_data_i;
      end
   end
`else
   logic unused_wb;
   assign unused_wb = ^{wb_rd_i, wb_regWrite_i, wb_data_i, rs1_i, rs2_i};
   assign opa = op1_i;
   assign opb = op2_i;
`endif

   always_comb begin
      wide = '0;
      res  = '0;
      cy   = 1'b0;
      case (alu_op_i)
         4'd0: begin
            wide = {1'b0, opa} + {1'b0, opb};
            res  = wide[DATA_W-1:0];
            cy   = wide[DATA_W];
         end
         4'd1: begin
            // Top bit of the widened difference is the unsigned borrow.
            wide = {1'b0, opa} - {1'b0, opb};
            res  = wide[DATA_W-1:0];
            cy   = wide[DATA_W];
         end
         4'd2: res = opa & opb;
         4'd3: res = opa | opb;
         4'd4: res = opa ^ opb;
         4'd5: res = ~opa;
         4'd6: res = opa << constant_i;
         4'd7: res = opa >> constant_i;
         4'd8: res = opb;
         4'd9: begin
            wide = {1'b0, opa} + {{(DATA_W-1){1'b0}}, constant_i};
            res  = wide[DATA_W-1:0];
            cy   = wide[DATA_W];
         end
         default: res = '0;
      endcase
   end

   always_comb begin
      alu_result_d = alu_result_q;
      store_data_d = store_data_q;
      rd_d         = rd_q;
      mem_read_d   = mem_read_q;
      mem_write_d  = mem_write_q;
      reg_write_d  = reg_write_q;
      zero_d       = zero_q;
      carry_d      = carry_q;
      if (!stall_i) begin
         if (flush_i) begin
            alu_result_d = '0;
            store_data_d = '0;
            rd_d         = '0;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
            reg_write_d  = 1'b0;
            zero_d       = 1'b0;
            carry_d      = 1'b0;
         end else begin
            alu_result_d = res;
            store_data_d = opb;
            rd_d         = rd_i;
            mem_read_d   = memRead_i;
            mem_write_d  = memWrite_i;
            reg_write_d  = regWrite_i;
            zero_d       = (res == '0);
            carry_d      = cy;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         alu_result_q <= '0;
         store_data_q <= '0;
         rd_q         <= '0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         reg_write_q  <= 1'b0;
         zero_q       <= 1'b0;
         carry_q      <= 1'b0;
      end else begin
         alu_result_q <= alu_result_d;
         store_data_q <= store_data_d;
         rd_q         <= rd_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         reg_write_q  <= reg_write_d;
         zero_q       <= zero_d;
         carry_q      <= carry_d;
      end
   end

   assign alu_result_o = alu_result_q;
   assign store_data_o = store_data_q;
   assign rd_o         = rd_q;
   assign memRead_o    = mem_read_q;
   assign memWrite_o   = mem_write_q;
   assign regWrite_o   = reg_write_q;
   assign zero_o       = zero_q;
   assign carry_o      = carry_q;

endmodule
